// File: rtl/dir_pkg.sv
// Shared types for the home-node directory: entry encodings, request codes,
// controller states and node-vector helpers.
package dir_pkg;

    localparam int NUM_NODES  = 4;
    localparam int NUM_BLOCKS = 16;
    localparam int NODE_W     = $clog2(NUM_NODES);
    localparam int ADDR_W     = $clog2(NUM_BLOCKS);

    localparam logic [1:0] ST_NONE     = 2'b00;
    localparam logic [1:0] ST_INVALID  = 2'b01;
    localparam logic [1:0] ST_SHARED   = 2'b10;
    localparam logic [1:0] ST_MODIFIED = 2'b11;

    localparam logic [2:0] REQ_READ_MISS  = 3'd1;
    localparam logic [2:0] REQ_WRITE_MISS = 3'd2;
    localparam logic [2:0] REQ_INVALIDATE = 3'd3;
    localparam logic [2:0] REQ_WRITE_BACK = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        FETCH  = 3'd2,
        INVAL  = 3'd3,
        REPLY  = 3'd4
    } dirFsm_e;

    typedef struct packed {
        logic [1:0]           state;
        logic [NUM_NODES-1:0] sharers;
    } dir_entry_t;

    function automatic logic [NUM_NODES-1:0] nodeOneHot(input logic [NODE_W-1:0] node);
        nodeOneHot       = '0;
        nodeOneHot[node] = 1'b1;
    endfunction

    // The owner of a MODIFIED block is its single sharer bit; lowest set bit wins.
    function automatic logic [NODE_W-1:0] lowestNode(input logic [NUM_NODES-1:0] vec);
        lowestNode = '0;
        for (int i = NUM_NODES - 1; i >= 0; i--) begin
            if (vec[i]) lowestNode = NODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/dir_entry_array.sv
// Directory storage: one synchronous write port, asynchronous lookup and debug
// read ports. Reset returns every block to uncached.
module dir_entry_array
    import dir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  dir_entry_t        wrData,
    input  logic [ADDR_W-1:0] lookupAddr,
    output dir_entry_t        lookupData,
    input  logic [ADDR_W-1:0] dbgAddr,
    output dir_entry_t        dbgData
);

    dir_entry_t entries [NUM_BLOCKS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                entries[i] <= '{state: ST_INVALID, sharers: '0};
            end
        end else if (wrEn) begin
            entries[wrAddr] <= wrData;
        end
    end

    assign lookupData = entries[lookupAddr];
    assign dbgData    = entries[dbgAddr];

endmodule

// File: rtl/directory_controller.sv
// Home-node directory controller: accepts one coherence request at a time and
// sequences fetch / invalidate / reply handshakes before committing the entry.
module directory_controller
    import dir_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_type,
    input  logic [NODE_W-1:0]    req_node,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 fetch_valid,
    output logic [NODE_W-1:0]    fetch_node,
    output logic                 fetch_inv,
    input  logic                 fetch_ack,
    output logic                 inv_valid,
    output logic [NUM_NODES-1:0] inv_mask,
    input  logic                 inv_ack,
    output logic                 reply_valid,
    output logic [NODE_W-1:0]    reply_node,
    output logic                 reply_data,
    input  logic                 reply_ack,
    output logic                 protocol_err,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [1:0]           dbg_state,
    output logic [NUM_NODES-1:0] dbg_sharers
);

    dirFsm_e              state, nextState;
    logic [2:0]           reqTypeR;
    logic [NODE_W-1:0]    reqNodeR, fetchNodeR, decOwner;
    logic [ADDR_W-1:0]    reqAddrR;
    logic [NUM_NODES-1:0] invMaskR, decInvMask, reqOneHot;
    logic                 fetchInvR, replyDataR, errR;
    logic                 decFetch, decFetchInv, decReply, decReplyData, decErr, isOwner;
    logic                 wrEn;
    dir_entry_t           lookupEntry, dbgEntry, decEntry, newEntryR, wrData;

    dir_entry_array entryArray (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrEn       (wrEn),
        .wrAddr     (reqAddrR),
        .wrData     (wrData),
        .lookupAddr (reqAddrR),
        .lookupData (lookupEntry),
        .dbgAddr    (dbg_addr),
        .dbgData    (dbgEntry)
    );

    // Protocol decision for the latched request against the current entry.
    // An upgrade that has lost its shared copy degrades to a full write miss.
    always_comb begin
        reqOneHot    = nodeOneHot(reqNodeR);
        decOwner     = lowestNode(lookupEntry.sharers);
        isOwner      = (lookupEntry.state == ST_MODIFIED) && (decOwner == reqNodeR);
        decFetch     = 1'b0;
        decFetchInv  = 1'b0;
        decInvMask   = '0;
        decReply     = 1'b1;
        decReplyData = 1'b1;
        decErr       = 1'b0;
        decEntry     = lookupEntry;
        case (reqTypeR)
            REQ_READ_MISS: begin
                case (lookupEntry.state)
                    ST_SHARED:   decEntry.sharers = lookupEntry.sharers | reqOneHot;
                    ST_MODIFIED: begin
                        if (!isOwner) begin
                            decFetch = 1'b1;
                            decEntry = '{state: ST_SHARED, sharers: nodeOneHot(decOwner) | reqOneHot};
                        end
                    end
                    default:     decEntry = '{state: ST_SHARED, sharers: reqOneHot};
                endcase
            end
            REQ_WRITE_MISS, REQ_INVALIDATE: begin
                decEntry = '{state: ST_MODIFIED, sharers: reqOneHot};
                case (lookupEntry.state)
                    ST_SHARED: begin
                        decInvMask   = lookupEntry.sharers & ~reqOneHot;
                        decReplyData = !((reqTypeR == REQ_INVALIDATE) &&
                                         (|(lookupEntry.sharers & reqOneHot)));
                    end
                    ST_MODIFIED: begin
                        if (isOwner) begin
                            decEntry     = lookupEntry;
                            decReplyData = (reqTypeR == REQ_WRITE_MISS);
                        end else begin
                            decFetch    = 1'b1;
                            decFetchInv = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            REQ_WRITE_BACK: begin
                decReply = 1'b0;
                if (isOwner) decEntry = '{state: ST_INVALID, sharers: '0};
                else         decErr   = 1'b1;
            end
            default: begin
                decReply = 1'b0;
                decErr   = 1'b1;
            end
        endcase
    end

    // Sequencing; the entry commits on the edge that closes the final handshake.
    always_comb begin
        nextState = state;
        wrEn      = 1'b0;
        wrData    = newEntryR;
        case (state)
            IDLE:   if (req_valid) nextState = LOOKUP;
            LOOKUP: begin
                if (decErr)            nextState = IDLE;
                else if (decFetch)     nextState = FETCH;
                else if (|decInvMask)  nextState = INVAL;
                else if (decReply)     nextState = REPLY;
                else begin
                    nextState = IDLE;
                    wrEn      = 1'b1;
                    wrData    = decEntry;
                end
            end
            FETCH:  if (fetch_ack) nextState = (|invMaskR) ? INVAL : REPLY;
            INVAL:  if (inv_ack)   nextState = REPLY;
            REPLY: begin
                if (reply_ack) begin
                    nextState = IDLE;
                    wrEn      = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            errR       <= 1'b0;
            reqTypeR   <= '0;
            reqNodeR   <= '0;
            reqAddrR   <= '0;
            newEntryR  <= '{state: ST_INVALID, sharers: '0};
            fetchNodeR <= '0;
            fetchInvR  <= 1'b0;
            invMaskR   <= '0;
            replyDataR <= 1'b0;
        end else begin
            state <= nextState;
            errR  <= (state == LOOKUP) && decErr;
            if (state == IDLE && req_valid) begin
                reqTypeR <= req_type;
                reqNodeR <= req_node;
                reqAddrR <= req_addr;
            end
            if (state == LOOKUP) begin
                newEntryR  <= decEntry;
                fetchNodeR <= decOwner;
                fetchInvR  <= decFetchInv;
                invMaskR   <= decInvMask;
                replyDataR <= decReplyData;
            end
        end
    end

    assign req_ready    = (state == IDLE);
    assign fetch_valid  = (state == FETCH);
    assign fetch_node   = fetchNodeR;
    assign fetch_inv    = fetchInvR;
    assign inv_valid    = (state == INVAL);
    assign inv_mask     = invMaskR;
    assign reply_valid  = (state == REPLY);
    assign reply_node   = reqNodeR;
    assign reply_data   = replyDataR;
    assign protocol_err = errR;
    assign dbg_state    = dbgEntry.state;
    assign dbg_sharers  = dbgEntry.sharers;

endmodule
